peak_frame_ctrl: RTL and testbench

- Sequences a downstream three-peak detector over a stream of FFT magnitude frames.
- Tracks frame boundaries and generates the per-beat bin index.
- Issues the detector clear/tlast pulse and snapshots the detector's top-3 values and indexes at each frame end.
- Presents each snapshot on a valid/ready result port; supports single-burst (N frames) and continuous capture.

---
 rtl/peak_frame_ctrl.sv | 154 +++++++++++++++
 tb/tb_peak_frame_ctrl.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/peak_frame_ctrl.sv
// Frame sequencer for a three-peak detector: bin indexing, detector clear and
// per-frame snapshot of the top-3 peaks onto a valid/ready result port.
module peak_frame_ctrl #(
  parameter int VALUE_WIDTH = 32,
  parameter int INDEX_WIDTH = 11,
  parameter int FCNT_WIDTH  = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cfg_start,
  input  logic                   cfg_stop,
  input  logic [FCNT_WIDTH-1:0]  cfg_num_frames,
  input  logic                   s_valid,
  input  logic                   s_last,
  output logic                   pd_valid,
  output logic [INDEX_WIDTH-1:0] pd_index,
  output logic                   pd_tlast,
  input  logic [VALUE_WIDTH-1:0] pd_top1,
  input  logic [VALUE_WIDTH-1:0] pd_top2,
  input  logic [VALUE_WIDTH-1:0] pd_top3,
  input  logic [INDEX_WIDTH-1:0] pd_index1,
  input  logic [INDEX_WIDTH-1:0] pd_index2,
  input  logic [INDEX_WIDTH-1:0] pd_index3,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [VALUE_WIDTH-1:0] res_top1,
  output logic [VALUE_WIDTH-1:0] res_top2,
  output logic [VALUE_WIDTH-1:0] res_top3,
  output logic [INDEX_WIDTH-1:0] res_idx1,
  output logic [INDEX_WIDTH-1:0] res_idx2,
  output logic [INDEX_WIDTH-1:0] res_idx3,
  output logic [FCNT_WIDTH-1:0]  res_frame,
  output logic                   busy,
  output logic                   done,
  output logic [7:0]             drop_count
);

  typedef enum logic [1:0] {IDLE, SYNC, RUN} state_t;

  state_t                          state_q, state_d;
  logic [INDEX_WIDTH-1:0]          cnt_q, cnt_d;
  logic [FCNT_WIDTH-1:0]           fcnt_q, fcnt_d, fcnt_inc;
  logic                            cap_q, cap_d;
  logic                            done_q, done_d;
  logic                            res_valid_q, res_valid_d;
  logic [7:0]                      drop_q, drop_d;
  logic [2:0][VALUE_WIDTH-1:0]     top_q, top_d;
  logic [2:0][INDEX_WIDTH-1:0]     idx_q, idx_d;
  logic [FCNT_WIDTH-1:0]           res_frame_q, res_frame_d;
  logic                            start_go, fin;

  assign start_go = (state_q == IDLE) && cfg_start && !cfg_stop;
  assign fcnt_inc = fcnt_q + 1'b1;
  assign fin      = cap_q && (cfg_num_frames != '0) && (fcnt_inc == cfg_num_frames)
                    && (state_q != IDLE);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    fcnt_d      = fcnt_q;
    cap_d       = 1'b0;
    done_d      = done_q;
    res_valid_d = res_valid_q;
    drop_d      = drop_q;
    top_d       = top_q;
    idx_d       = idx_q;
    res_frame_d = res_frame_q;

    if (res_valid_q && res_ready) res_valid_d = 1'b0;

    // Detector registers already hold the last beat when cap_q is high.
    if (cap_q) begin
      if (!res_valid_q || res_ready) begin
        res_valid_d = 1'b1;
        top_d       = {pd_top3, pd_top2, pd_top1};
        idx_d       = {pd_index3, pd_index2, pd_index1};
        res_frame_d = fcnt_q;
      end else if (drop_q != 8'hFF) begin
        drop_d = drop_q + 8'd1;
      end
      fcnt_d = fcnt_inc;
    end

    case (state_q)
      IDLE: if (start_go) begin
        state_d = SYNC;
        done_d  = 1'b0;
        drop_d  = '0;
        fcnt_d  = '0;
      end
      SYNC: if (s_valid && s_last) begin
        state_d = RUN;
        cnt_d   = '0;
      end
      RUN: if (s_valid) begin
        if (s_last) begin
          cnt_d = '0;
          cap_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (fin) done_d = 1'b1;
    if (fin || cfg_stop) begin
      state_d = IDLE;
      cap_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      fcnt_q      <= '0;
      cap_q       <= 1'b0;
      done_q      <= 1'b0;
      res_valid_q <= 1'b0;
      drop_q      <= '0;
      top_q       <= '0;
      idx_q       <= '0;
      res_frame_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      fcnt_q      <= fcnt_d;
      cap_q       <= cap_d;
      done_q      <= done_d;
      res_valid_q <= res_valid_d;
      drop_q      <= drop_d;
      top_q       <= top_d;
      idx_q       <= idx_d;
      res_frame_q <= res_frame_d;
    end
  end

  assign pd_valid   = (state_q == RUN) && s_valid;
  assign pd_index   = cnt_q;
  assign pd_tlast   = cap_q || start_go;
  assign res_valid  = res_valid_q;
  assign res_top1   = top_q[0];
  assign res_top2   = top_q[1];
  assign res_top3   = top_q[2];
  assign res_idx1   = idx_q[0];
  assign res_idx2   = idx_q[1];
  assign res_idx3   = idx_q[2];
  assign res_frame  = res_frame_q;
  assign busy       = (state_q != IDLE);
  assign done       = done_q;
  assign drop_count = drop_q;

endmodule

// File: tb/tb_peak_frame_ctrl.sv
// Scoreboard bench for peak_frame_ctrl with a behavioural top-3 detector.
module tb_peak_frame_ctrl;
  logic        clk = 1'b0;
  logic        rst, cfg_start, cfg_stop, s_valid, s_last, res_ready;
  logic [15:0] cfg_num_frames;
  logic        pd_valid, pd_tlast, res_valid, busy, done;
  logic [10:0] pd_index, res_idx1, res_idx2, res_idx3;
  logic [31:0] res_top1, res_top2, res_top3;
  logic [15:0] res_frame;
  logic [7:0]  drop_count;
  logic [31:0] mag;
  logic [31:0] t0, t1, t2;
  logic [10:0] i0, i1, i2;

  typedef struct packed {
    logic [31:0] a1, a2, a3;
    logic [10:0] x1, x2, x3;
    logic [15:0] fr;
  } res_t;

  res_t expq[$];
  res_t got, want;
  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  peak_frame_ctrl dut (
    .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_stop(cfg_stop),
    .cfg_num_frames(cfg_num_frames), .s_valid(s_valid), .s_last(s_last),
    .pd_valid(pd_valid), .pd_index(pd_index), .pd_tlast(pd_tlast),
    .pd_top1(t0), .pd_top2(t1), .pd_top3(t2),
    .pd_index1(i0), .pd_index2(i1), .pd_index3(i2),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_top1(res_top1), .res_top2(res_top2), .res_top3(res_top3),
    .res_idx1(res_idx1), .res_idx2(res_idx2), .res_idx3(res_idx3),
    .res_frame(res_frame), .busy(busy), .done(done), .drop_count(drop_count)
  );

  // Detector: clears on tlast, only second-half bins compete for top-3.
  always @(posedge clk) begin
    if (rst || pd_tlast) begin
      t0 <= '0; t1 <= '0; t2 <= '0; i0 <= '0; i1 <= '0; i2 <= '0;
    end else if (pd_valid && pd_index >= 11'd1024) begin
      if (mag > t0) begin
        t0 <= mag; i0 <= pd_index; t1 <= t0; i1 <= i0; t2 <= t1; i2 <= i1;
      end else if (mag > t1) begin
        t1 <= mag; i1 <= pd_index; t2 <= t1; i2 <= i1;
      end else if (mag > t2) begin
        t2 <= mag; i2 <= pd_index;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && res_valid && res_ready) begin
      got = {res_top1, res_top2, res_top3, res_idx1, res_idx2, res_idx3, res_frame};
      checks++;
      if (expq.size() == 0) begin
        failures++;
        $display("FAIL result_unexpected actual=%h required=none", got);
      end else begin
        want = expq.pop_front();
        if (got !== want) begin
          failures++;
          $display("FAIL result actual=%h required=%h", got, want);
        end
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  function automatic logic [31:0] magf(input int kind, input int b);
    if (kind == 1 && b == 2047) return 32'hFFFF_FFFF;
    if (b == 1100) return 32'd800;
    if (b == 1500) return 32'd900;
    if (b == 1900) return 32'd700;
    return 32'd10;
  endfunction

  function automatic res_t mk(input int kind, input logic [15:0] fr);
    if (kind == 1) return {32'hFFFF_FFFF, 32'd900, 32'd800, 11'd2047, 11'd1500, 11'd1100, fr};
    return {32'd900, 32'd800, 32'd700, 11'd1500, 11'd1100, 11'd1900, fr};
  endfunction

  // Drives n beats; sync frames must not reach the detector, run frames must
  // index 0..n-1 with tlast only on beat 0 when tl0 says a capture is due.
  task automatic frame(input int n, input bit last, input int kind, input bit sync, input bit tl0);
    int bad = 0;
    for (int b = 0; b < n; b++) begin
      s_valid = 1'b1;
      s_last  = last && (b == n - 1);
      mag     = magf(kind, b);
      @(negedge clk);
      if (sync) begin
        if (pd_valid) bad++;
      end else if (!pd_valid || pd_index != b[10:0] || pd_tlast != ((b == 0) ? tl0 : 1'b0)) begin
        bad++;
      end
      tick();
    end
    check(sync ? "sync_beats" : "run_beats", bad, 0);
  endtask

  task automatic idle(input int n);
    s_valid = 1'b0; s_last = 1'b0;
    repeat (n) tick();
  endtask

  task automatic start();
    cfg_start = 1'b1; tick(); cfg_start = 1'b0;
  endtask

  task automatic stop();
    cfg_stop = 1'b1; tick(); cfg_stop = 1'b0;
  endtask

  initial begin
    rst = 1'b1; cfg_start = 1'b0; cfg_stop = 1'b0; s_valid = 1'b1; s_last = 1'b0;
    res_ready = 1'b0; cfg_num_frames = '0; mag = '0;
    repeat (3) tick();
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_pd", {pd_valid, pd_tlast, pd_index}, 0);
    check("rst_done_drop", {done, drop_count}, 0);
    tick();
    rst = 1'b0; s_valid = 1'b0;
    tick();

    // Burst of two frames after a discarded sync frame.
    cfg_num_frames = 16'd2; res_ready = 1'b1;
    start();
    frame(2048, 1, 0, 1, 0);
    expq.push_back(mk(0, 16'd0));
    frame(2048, 1, 0, 0, 0);
    idle(4);
    @(negedge clk);
    check("t1_mid_busy_done", {busy, done}, 2'b10);
    tick();
    expq.push_back(mk(0, 16'd1));
    frame(2048, 1, 0, 0, 0);
    idle(4);
    @(negedge clk);
    check("t1_end_busy_done", {busy, done}, 2'b01);
    check("t1_queue", expq.size(), 0);
    tick();

    // Continuous capture with the consumer stalled.
    cfg_num_frames = 16'd0; res_ready = 1'b0;
    start();
    @(negedge clk);
    check("t2_done_cleared", done, 0);
    tick();
    frame(2048, 1, 0, 1, 0);
    expq.push_back(mk(0, 16'd0));
    frame(2048, 1, 0, 0, 0);
    frame(2048, 1, 0, 0, 1);
    frame(2048, 1, 0, 0, 1);
    frame(2048, 1, 0, 0, 1);
    idle(3);
    @(negedge clk);
    check("t2_held", {res_valid, res_frame, res_top1}, {1'b1, 16'd0, 32'd900});
    check("t2_drops", drop_count, 3);
    tick();
    stop();
    res_ready = 1'b1;
    tick();
    @(negedge clk);
    check("t2_after_hs", {res_valid, busy, done}, 0);
    check("t2_queue", expq.size(), 0);
    check("t2_drops_kept", drop_count, 3);
    tick();

    // Abort mid-frame, then restart.
    start();
    @(negedge clk);
    check("t5_cleared", {busy, done, drop_count}, {1'b1, 1'b0, 8'd0});
    tick();
    frame(2048, 1, 0, 1, 0);
    frame(700, 0, 0, 0, 0);
    s_valid = 1'b1; s_last = 1'b0;
    stop();
    frame(600, 1, 0, 1, 0);
    idle(2);
    start();
    frame(501, 1, 0, 1, 0);
    expq.push_back(mk(0, 16'd0));
    frame(2048, 1, 0, 0, 0);
    idle(4);
    @(negedge clk);
    check("t5_queue", expq.size(), 0);
    tick();
    stop();
    idle(2);

    // Back-to-back frames at full rate.
    cfg_num_frames = 16'd3;
    start();
    frame(2048, 1, 0, 1, 0);
    for (int f = 0; f < 3; f++) begin
      expq.push_back(mk(0, f[15:0]));
      frame(2048, 1, 0, 0, f != 0);
    end
    idle(4);
    @(negedge clk);
    check("t3_end_busy_done", {busy, done}, 2'b01);
    check("t3_queue", expq.size(), 0);
    tick();

    // Peak on the final beat.
    cfg_num_frames = 16'd1;
    start();
    frame(2048, 1, 0, 1, 0);
    expq.push_back(mk(1, 16'd0));
    frame(2048, 1, 1, 0, 0);
    idle(4);
    @(negedge clk);
    check("t4_queue", expq.size(), 0);
    check("t4_done", done, 1);
    tick();

    // Start and stop together: stop wins.
    cfg_start = 1'b1; cfg_stop = 1'b1; tick();
    cfg_start = 1'b0; cfg_stop = 1'b0;
    idle(2);
    @(negedge clk);
    check("t6_stop_wins", {busy, done}, 2'b01);
    tick();

    // Reset mid-frame with a result pending.
    cfg_num_frames = 16'd0; res_ready = 1'b0;
    start();
    frame(2048, 1, 0, 1, 0);
    frame(2048, 1, 0, 0, 0);
    idle(3);
    @(negedge clk);
    check("t6_pending", res_valid, 1);
    tick();
    frame(300, 0, 0, 0, 0);
    s_valid = 1'b1;
    rst = 1'b1;
    tick();
    @(negedge clk);
    check("t6_rst_ctl", {busy, done, drop_count, res_valid}, 0);
    check("t6_rst_pd", {pd_valid, pd_tlast, pd_index}, 0);
    check("t6_rst_res", {res_top1, res_top2, res_top3, res_frame}, 0);
    tick();
    rst = 1'b0; s_valid = 1'b0;
    idle(2);
    check("final_queue", expq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
